// File: rtl/transformer_4x4_pkg.sv
// Shared types for the 4x4 forward integer transform.
// State encoding, intermediate width and block geometry.
package idaten_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROW,
    COL,
    DONE
  } tx_state_e;

  localparam int INTER_W = 11;
  localparam int BLK     = 4;
  localparam int NCOEF   = BLK * BLK;

  function automatic logic [3:0] rc_idx(
    input logic [1:0] r,
    input logic [1:0] c
  );
    return {r, c};
  endfunction

endpackage

// File: rtl/transformer_4x4_dct1d_4.sv
// Combinational 4-point H.264 forward core butterfly.
// Inputs are sign-extended to OUT_W before any arithmetic.
module dct1d_4
  import idaten_tx_pkg::*;
#(
  parameter int IN_W  = INTER_W,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  x [BLK],
  output logic signed [OUT_W-1:0] y [BLK]
);

  logic signed [OUT_W-1:0] e [BLK];
  logic signed [OUT_W-1:0] a;
  logic signed [OUT_W-1:0] b;
  logic signed [OUT_W-1:0] c;
  logic signed [OUT_W-1:0] d;

  always_comb begin
    for (int i = 0; i < BLK; i++) begin
      e[i] = {{(OUT_W-IN_W){x[i][IN_W-1]}}, x[i]};
    end
    a    = e[0] + e[3];
    b    = e[1] + e[2];
    c    = e[1] - e[2];
    d    = e[0] - e[3];
    y[0] = a + b;
    y[1] = (d <<< 1) + c;
    y[2] = a - b;
    y[3] = d - (c <<< 1);
  end

endmodule

// File: rtl/transformer_4x4.sv
// 4x4 forward integer transform: row pass then column pass, one line per cycle.
// Optional out_nonzero port enabled by TRANSFORMER_NONZERO_FLAG_EN.
module transformer_4x4
  import idaten_tx_pkg::*;
#(
  parameter int MB_NUMBER_BITS = 12,
  parameter int RES_W          = 8,
  parameter int COEFF_W        = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [RES_W-1:0]     in_res [NCOEF],
  input  logic [2:0]                  in_mode,
  input  logic [MB_NUMBER_BITS:0]     in_mbnumber,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [COEFF_W-1:0]   out_coeff [NCOEF],
  output logic [2:0]                  out_mode,
`ifdef TRANSFORMER_NONZERO_FLAG_EN
  output logic                        out_nonzero,
`endif
  output logic [MB_NUMBER_BITS:0]     out_mbnumber
);

  if (COEFF_W < RES_W + 6 || RES_W + 3 > INTER_W) begin : g_w_chk
    $error("transformer_4x4: need COEFF_W >= RES_W+6 and RES_W+3 <= INTER_W");
  end

  tx_state_e state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic rdy_q, rdy_d;
  logic valid_q, valid_d;
  logic [2:0] mode_q, mode_d;
  logic [MB_NUMBER_BITS:0] mb_q, mb_d;
  logic signed [RES_W-1:0] res_q [NCOEF];
  logic signed [RES_W-1:0] res_d [NCOEF];
  logic signed [INTER_W-1:0] inter_q [NCOEF];
  logic signed [INTER_W-1:0] inter_d [NCOEF];
  logic signed [COEFF_W-1:0] coeff_q [NCOEF];
  logic signed [COEFF_W-1:0] coeff_d [NCOEF];

  logic signed [INTER_W-1:0] bf_x [BLK];
  logic signed [COEFF_W-1:0] bf_y [BLK];
  logic accept;

  assign accept = (state_q == IDLE) && in_valid && rdy_q;

  // Shared butterfly: residual rows in ROW, buffered columns in COL.
  always_comb begin
    logic signed [RES_W-1:0] rv;
    rv = '0;
    for (int k = 0; k < BLK; k++) begin
      rv = res_q[rc_idx(idx_q, 2'(k))];
      if (state_q == COL) begin
        bf_x[k] = inter_q[rc_idx(2'(k), idx_q)];
      end else begin
        bf_x[k] = {{(INTER_W-RES_W){rv[RES_W-1]}}, rv};
      end
    end
  end

  dct1d_4 #(
    .IN_W  (INTER_W),
    .OUT_W (COEFF_W)
  ) u_bfly (
    .x (bf_x),
    .y (bf_y)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    mb_d    = mb_q;
    res_d   = res_q;
    inter_d = inter_q;
    coeff_d = coeff_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          res_d   = in_res;
          mode_d  = in_mode;
          mb_d    = in_mbnumber;
          idx_d   = 2'd0;
          state_d = ROW;
        end
      end
      ROW: begin
        for (int k = 0; k < BLK; k++) begin
          inter_d[rc_idx(idx_q, 2'(k))] = bf_y[k][INTER_W-1:0];
        end
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = COL;
      end
      COL: begin
        for (int k = 0; k < BLK; k++) begin
          coeff_d[rc_idx(2'(k), idx_q)] = bf_y[k];
        end
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rdy_d   = (state_d == IDLE);
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rdy_q   <= 1'b0;
      valid_q <= 1'b0;
      mode_q  <= '0;
      mb_q    <= '0;
      for (int i = 0; i < NCOEF; i++) begin
        res_q[i]   <= '0;
        inter_q[i] <= '0;
        coeff_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rdy_q   <= rdy_d;
      valid_q <= valid_d;
      mode_q  <= mode_d;
      mb_q    <= mb_d;
      res_q   <= res_d;
      inter_q <= inter_d;
      coeff_q <= coeff_d;
    end
  end

  assign in_ready     = rdy_q;
  assign out_valid    = valid_q;
  assign out_coeff    = coeff_q;
  assign out_mode     = mode_q;
  assign out_mbnumber = mb_q;

`ifdef TRANSFORMER_NONZERO_FLAG_EN
  logic nz_q, nz_d;

  always_comb begin
    nz_d = nz_q;
    if (accept) begin
      nz_d = 1'b0;
    end else if (state_q == COL) begin
      for (int k = 0; k < BLK; k++) begin
        nz_d = nz_d | (bf_y[k] != '0);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) nz_q <= 1'b0;
    else        nz_q <= nz_d;
  end

  assign out_nonzero = nz_q;
`endif

endmodule

// File: tb/tb_transformer_4x4.sv
// Self-checking bench for transformer_4x4 against a matrix-product model.
// Directed blocks, backpressure, mid-block reset and random traffic.
module tb_transformer_4x4;

  localparam int MBB = 12;
  localparam int RW  = 8;
  localparam int CW  = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready;
  logic out_valid;
  logic signed [RW-1:0] in_res [16];
  logic [2:0] in_mode = '0;
  logic [2:0] out_mode;
  logic [MBB:0] in_mbnumber = '0;
  logic [MBB:0] out_mbnumber;
  logic signed [CW-1:0] out_coeff [16];
`ifdef TRANSFORMER_NONZERO_FLAG_EN
  logic out_nonzero;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int ecnt = 0;

  bit exp_ready = 1'b0;
  bit pend = 1'b0;
  int exp_c [16];
  logic [2:0] exp_mode;
  logic [MBB:0] exp_mb;
  int exp_acc = 0;
  bit exp_nz = 1'b0;

  int hold = 0;
  bit bp_rand = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) ecnt = ecnt + 1;

  transformer_4x4 #(
    .MB_NUMBER_BITS (MBB),
    .RES_W          (RW),
    .COEFF_W        (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_res       (in_res),
    .in_mode      (in_mode),
    .in_mbnumber  (in_mbnumber),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_coeff    (out_coeff),
    .out_mode     (out_mode),
`ifdef TRANSFORMER_NONZERO_FLAG_EN
    .out_nonzero  (out_nonzero),
`endif
    .out_mbnumber (out_mbnumber)
  );

  // C = M * X * M^T with the H.264 forward core matrix M.
  function automatic void fwd(input int x [16], output int c [16]);
    int m [4][4];
    int s;
    m = '{'{1, 1, 1, 1}, '{2, 1, -1, -2}, '{1, -1, -1, 1}, '{1, -2, 2, -1}};
    for (int v = 0; v < 4; v++) begin
      for (int h = 0; h < 4; h++) begin
        s = 0;
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++)
            s += m[v][i] * x[4*i+j] * m[h][j];
        c[4*v+h] = s;
      end
    end
  endfunction

  function automatic void chk(input string nm, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got %0d want %0d at %0t", nm, got, want, $time);
    end
  endfunction

  always @(negedge clk) begin
    int xs [16];
    int zc;
    bit ev;
    if (!reset) begin
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_mode", int'(out_mode), 0);
      chk("rst_mb", int'(out_mbnumber), 0);
      zc = 0;
      for (int i = 0; i < 16; i++) if (out_coeff[i] != 0) zc++;
      chk("rst_coeff_nonzero_cnt", zc, 0);
      pend = 1'b0;
      exp_ready = 1'b1;
    end else begin
      ev = pend && (ecnt >= exp_acc + 8);
      chk("in_ready", int'(in_ready), int'(exp_ready));
      chk("out_valid", int'(out_valid), int'(ev));
      if (ev && out_valid) begin
        for (int i = 0; i < 16; i++)
          chk($sformatf("coeff%0d", i), int'(out_coeff[i]), exp_c[i]);
        chk("mode", int'(out_mode), int'(exp_mode));
        chk("mbnumber", int'(out_mbnumber), int'(exp_mb));
`ifdef TRANSFORMER_NONZERO_FLAG_EN
        chk("nonzero", int'(out_nonzero), int'(exp_nz));
`endif
      end
      if (ev && out_ready) begin
        pend = 1'b0;
        exp_ready = 1'b1;
      end else if (in_valid && exp_ready) begin
        for (int i = 0; i < 16; i++) xs[i] = int'(in_res[i]);
        fwd(xs, exp_c);
        exp_nz = 1'b0;
        for (int i = 0; i < 16; i++) if (exp_c[i] != 0) exp_nz = 1'b1;
        exp_mode = in_mode;
        exp_mb = in_mbnumber;
        exp_acc = ecnt + 1;
        pend = 1'b1;
        exp_ready = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (hold > 0) begin
      out_ready = 1'b0;
      hold--;
    end else begin
      out_ready = bp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic send(input int r [16], input int m, input int mb);
    int n;
    tick();
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) in_res[i] = RW'(r[i]);
    in_mode = 3'(m);
    in_mbnumber = (MBB+1)'(mb);
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 60) begin
        n_cmp++;
        n_bad++;
        $display("FAIL accept_timeout got busy want ready at %0t", $time);
        break;
      end
      tick();
    end
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    int blk [16];
    int pc [16];
    int imp [16];
    int cnt;
    int n;
    for (int i = 0; i < 16; i++) in_res[i] = '0;

    for (int i = 0; i < 16; i++) blk[i] = 1;
    fwd(blk, pc);
    chk("pin_ones_dc", pc[0], 16);
    cnt = 0;
    for (int i = 1; i < 16; i++) if (pc[i] != 0) cnt++;
    chk("pin_ones_ac_cnt", cnt, 0);
    for (int i = 0; i < 16; i++) blk[i] = -128;
    fwd(blk, pc);
    chk("pin_m128_dc", pc[0], -2048);
    imp = '{1, 2, 1, 1, 2, 4, 2, 2, 1, 2, 1, 1, 1, 2, 1, 1};
    for (int i = 0; i < 16; i++) blk[i] = 0;
    blk[0] = 1;
    fwd(blk, pc);
    for (int i = 0; i < 16; i++) chk($sformatf("pin_imp%0d", i), pc[i], imp[i]);

    repeat (3) @(negedge clk);
    #1 reset = 1'b1;

    for (int i = 0; i < 16; i++) blk[i] = 0;
    send(blk, 3, 17);
    for (int i = 0; i < 16; i++) blk[i] = 1;
    send(blk, 1, 2);
    for (int i = 0; i < 16; i++) blk[i] = -128;
    send(blk, 7, 8191);
    for (int i = 0; i < 16; i++) blk[i] = 0;
    blk[0] = 1;
    send(blk, 2, 5);
    for (int i = 0; i < 16; i++) begin
      if (i < 8) blk[i] = ((i % 4) < 2) ? 127 : -128;
      else blk[i] = ((i % 4) < 2) ? -128 : 127;
    end
    send(blk, 4, 100);
    for (int i = 0; i < 16; i++) blk[i] = 0;
    blk[15] = -1;
    send(blk, 5, 33);

    for (int i = 0; i < 16; i++) blk[i] = $urandom_range(0, 255) - 128;
    send(blk, 6, 1234);
    hold = 14;
    for (int i = 0; i < 16; i++) blk[i] = $urandom_range(0, 255) - 128;
    send(blk, 0, 4321);
    repeat (12) tick();

    for (int i = 0; i < 16; i++) blk[i] = 9;
    send(blk, 1, 77);
    repeat (5) tick();
    reset = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    repeat (3) tick();

    bp_rand = 1'b1;
    repeat (40) begin
      for (int i = 0; i < 16; i++) blk[i] = $urandom_range(0, 255) - 128;
      send(blk, $urandom_range(0, 7), $urandom_range(0, 8191));
      repeat ($urandom_range(0, 3)) tick();
    end

    bp_rand = 1'b0;
    n = 0;
    while (pend && n < 100) begin
      tick();
      n++;
    end
    chk("drain_pending", int'(pend), 0);
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
